change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: EJECT_GAP, default 4, idle cycles required between coin ejections (range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 change_in  input  16  change amount in cents, unsigned, from vending_machine change output.
REQ-005 change_valid  input  1  request strobe; change_in is sampled on any rising edge where change_valid=1 and busy=0.
REQ-006 hopper_empty  input  4  per-denomination empty flags; bit3=100c, bit2=25c, bit1=10c, bit0=5c.
REQ-007 busy  output  1  high from the edge sampling a request until the edge ending DONE.
REQ-008 coin_eject  output  4  one-hot eject pulse, same bit mapping as hopper_empty; one cycle wide.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 residue  output  16  undispensed cents; valid when done=1, held until next request is sampled.
REQ-011 coin_count  output  8  coins ejected for current request, saturates at 255.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, SELECT, EJECT, GAP, DONE; all outputs registered or decoded from state only.
REQ-013 IDLE: busy=0; on change_valid=1, latch change_in into a 16-bit remaining register, clear coin_count and residue, go to SELECT (or DONE if change_in=0).
REQ-014 SELECT: pick the largest denomination d in {100,25,10,5} with remaining>=d and hopper_empty[d]=0; if found go to EJECT, else go to DONE.
REQ-015 EJECT: assert coin_eject for d for exactly one cycle; on exit remaining -= d (no underflow possible), coin_count += 1 saturating; go to GAP.
REQ-016 GAP: remain EJECT_GAP cycles via down-counter, then go to SELECT.
REQ-017 DONE: assert done for one cycle, drive residue=remaining, go to IDLE.
REQ-018 Latency: first coin_eject pulse SHALL be high in the second cycle after the sampling edge; consecutive pulses SHALL be EJECT_GAP+2 cycles apart.
REQ-019 change_valid while busy=1 SHALL be ignored (no queuing).
REQ-020 hopper_empty SHALL be evaluated only in SELECT; a flag change during GAP affects the next selection only.
REQ-021 Remaining amounts 1..4 cents, or amounts no non-empty denomination can cover, SHALL end in DONE with nonzero residue.
REQ-022 Request may be re-sampled on the edge immediately after DONE (IDLE reached).

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, busy=0, coin_eject=0, done=0, residue=0, coin_count=0, remaining=0, gap counter=0.
REQ-024 Reset mid-EJECT SHALL terminate the pulse immediately; no partial request resumes after reset release.

Structure
REQ-025 Shared package vend_pkg SHALL hold denomination constants (100,25,10,5), coin bit indices, and the FSM state enum.
REQ-026 One combinational sub-module change_denom_select (inputs remaining, hopper_empty; outputs one-hot select and found flag) SHALL implement the priority pick.

Verification
REQ-027 change_in=65, hopper_empty=0 -> eject 25,25,10,5; done with residue=0, coin_count=4.
REQ-028 change_in=100, hopper_empty=4'b1000 -> four 25c pulses spaced EJECT_GAP+2 cycles; residue=0, coin_count=4.
REQ-029 change_in=7 -> one 5c pulse; done with residue=2, coin_count=1.
REQ-030 change_in=0 -> done one cycle after sampling edge, no coin_eject, residue=0.
REQ-031 change_in=75, second change_valid=1 with change_in=50 during GAP -> only three 25c pulses; second request ignored.
REQ-032 change_in=200, reset asserted during second EJECT -> coin_eject drops same cycle; all outputs 0; no further pulses after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared constants for the change dispenser: coin values, hopper bit positions and FSM states.
// Coin bit mapping is the same everywhere: bit3=100c, bit2=25c, bit1=10c, bit0=5c.
package vend_pkg;

   localparam logic [15:0] DENOM_100 = 16'd100;
   localparam logic [15:0] DENOM_25  = 16'd25;
   localparam logic [15:0] DENOM_10  = 16'd10;
   localparam logic [15:0] DENOM_5   = 16'd5;

   localparam int COIN_100 = 3;
   localparam int COIN_25  = 2;
   localparam int COIN_10  = 1;
   localparam int COIN_5   = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_GAP,
      ST_DONE
   } state_t;

   // Cent value of a one-hot coin select; zero for anything that is not one-hot.
   function automatic logic [15:0] coin_value(input logic [3:0] sel);
      logic [15:0] v;
      case (sel)
         4'b1000: v = DENOM_100;
         4'b0100: v = DENOM_25;
         4'b0010: v = DENOM_10;
         4'b0001: v = DENOM_5;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/change_denom_select.sv
// Picks the largest coin that fits the remaining amount and whose hopper is not empty.
// Purely combinational; o_found is low when no available coin fits.
module change_denom_select
   import vend_pkg::*;
(
   input  logic [15:0] i_remaining,
   input  logic [3:0]  i_hopper_empty,
   output logic [3:0]  o_sel,
   output logic        o_found
);

   always_comb begin
      o_sel = 4'b0000;
      if (!i_hopper_empty[COIN_100] && (i_remaining >= DENOM_100)) begin
         o_sel[COIN_100] = 1'b1;
      end else if (!i_hopper_empty[COIN_25] && (i_remaining >= DENOM_25)) begin
         o_sel[COIN_25] = 1'b1;
      end else if (!i_hopper_empty[COIN_10] && (i_remaining >= DENOM_10)) begin
         o_sel[COIN_10] = 1'b1;
      end else if (!i_hopper_empty[COIN_5] && (i_remaining >= DENOM_5)) begin
         o_sel[COIN_5] = 1'b1;
      end
   end

   assign o_found = |o_sel;

endmodule

// File: rtl/change_dispenser.sv
// Dispenses a change amount as a greedy sequence of one-cycle coin ejections separated by EJECT_GAP idle cycles.
// First pulse two cycles after the sampling edge, then every EJECT_GAP+2 cycles; requests arriving while busy are dropped.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned EJECT_GAP = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] change_in,
   input  logic        change_valid,
   input  logic [3:0]  hopper_empty,
   output logic        busy,
   output logic [3:0]  coin_eject,
   output logic        done,
   output logic [15:0] residue,
   output logic [7:0]  coin_count
);

   localparam logic [7:0] GAP_LOAD = 8'(EJECT_GAP - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_remaining;
   logic [3:0]  r_sel;
   logic [7:0]  r_gap_cnt;
   logic [7:0]  r_coin_count;
   logic [15:0] r_residue;
   logic [3:0]  w_pick;
   logic        w_found;

   change_denom_select u_denom_select (
      .i_remaining    (r_remaining),
      .i_hopper_empty (hopper_empty),
      .o_sel          (w_pick),
      .o_found        (w_found)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (change_valid) begin
               w_next = (change_in == 16'd0) ? ST_DONE : ST_SELECT;
            end
         end
         ST_SELECT: w_next = w_found ? ST_EJECT : ST_DONE;
         ST_EJECT:  w_next = ST_GAP;
         ST_GAP: begin
            if (r_gap_cnt == 8'd0) begin
               w_next = ST_SELECT;
            end
         end
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_remaining  <= 16'd0;
         r_sel        <= 4'b0000;
         r_gap_cnt    <= 8'd0;
         r_coin_count <= 8'd0;
         r_residue    <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (change_valid) begin
                  r_remaining  <= change_in;
                  r_coin_count <= 8'd0;
                  r_residue    <= 16'd0;
               end
            end
            ST_SELECT: begin
               // Residue is captured on the way into DONE so it is stable while done is high.
               if (w_found) begin
                  r_sel <= w_pick;
               end else begin
                  r_residue <= r_remaining;
               end
            end
            ST_EJECT: begin
               r_remaining <= r_remaining - coin_value(r_sel);
               r_gap_cnt   <= GAP_LOAD;
               if (r_coin_count != 8'd255) begin
                  r_coin_count <= r_coin_count + 8'd1;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt != 8'd0) begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Decoding the pulse from state lets an asynchronous reset cut it off mid-cycle.
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign coin_eject = (r_state == ST_EJECT) ? r_sel : 4'b0000;
   assign residue    = r_residue;
   assign coin_count = r_coin_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a greedy change-making reference model.
module tb_change_dispenser;

   localparam int G = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] change_in;
   logic        change_valid;
   logic [3:0]  hopper_empty;
   logic        busy;
   logic [3:0]  coin_eject;
   logic        done;
   logic [15:0] residue;
   logic [7:0]  coin_count;

   int n_cmp = 0;
   int n_bad = 0;

   int exp_val[$];
   int exp_res;

   change_dispenser #(.EJECT_GAP(G)) dut (
      .clk          (clk),
      .reset        (reset),
      .change_in    (change_in),
      .change_valid (change_valid),
      .hopper_empty (hopper_empty),
      .busy         (busy),
      .coin_eject   (coin_eject),
      .done         (done),
      .residue      (residue),
      .coin_count   (coin_count)
   );

   always #5 clk = ~clk;

   // Greedy change making; the first pick sees he1, every later pick sees he2.
   function automatic void build_model(input int amt, input logic [3:0] he1, input logic [3:0] he2);
      int rem;
      int denom[4];
      int pick;
      logic [3:0] he;
      denom[0] = 100; denom[1] = 25; denom[2] = 10; denom[3] = 5;
      rem = amt;
      exp_val.delete();
      while (1) begin
         he = (exp_val.size() == 0) ? he1 : he2;
         pick = 0;
         for (int k = 0; k < 4; k++) begin
            if (pick == 0 && rem >= denom[k] && !he[3-k]) pick = denom[k];
         end
         if (pick == 0) break;
         exp_val.push_back(pick);
         rem = rem - pick;
      end
      exp_res = rem;
   endfunction

   function automatic logic [3:0] bit_of(input int val);
      case (val)
         100:     return 4'b1000;
         25:      return 4'b0100;
         10:      return 4'b0010;
         5:       return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic run_req(input string name, input int amt, input logic [3:0] he1,
                          input logic [3:0] he2, input bit redrive);
      int n;
      int exp_done;
      int idx;
      int exp_cnt;
      logic [3:0] exp_ce;
      build_model(amt, he1, he2);
      n = exp_val.size();
      exp_done = (amt == 0) ? 1 : 2 + n * (G + 2);
      exp_cnt = (n > 255) ? 255 : n;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle_busy: got %b want 0", name, busy);
      end
      hopper_empty = he1;
      change_in = amt[15:0];
      change_valid = 1'b1;
      for (int cyc = 1; cyc <= exp_done; cyc++) begin
         @(negedge clk);
         exp_ce = 4'b0000;
         idx = cyc - 2;
         if (cyc >= 2 && (idx % (G + 2)) == 0 && (idx / (G + 2)) < n)
            exp_ce = bit_of(exp_val[idx / (G + 2)]);
         n_cmp++;
         if (coin_eject !== exp_ce) begin
            n_bad++;
            $display("FAIL %s coin_eject cyc %0d: got %b want %b", name, cyc, coin_eject, exp_ce);
         end
         n_cmp++;
         if (done !== (cyc == exp_done)) begin
            n_bad++;
            $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, done, (cyc == exp_done));
         end
         n_cmp++;
         if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy cyc %0d: got %b want 1", name, cyc, busy);
         end
         if (cyc == 1) change_valid = 1'b0;
         if (cyc == 3) begin
            hopper_empty = he2;
            if (redrive) begin
               change_valid = 1'b1;
               change_in = 16'd50;
            end
         end
         if (cyc == 3 + G) change_valid = 1'b0;
      end
      change_valid = 1'b0;
      n_cmp++;
      if (residue !== exp_res[15:0]) begin
         n_bad++;
         $display("FAIL %s residue: got %0d want %0d", name, residue, exp_res);
      end
      n_cmp++;
      if (coin_count !== exp_cnt[7:0]) begin
         n_bad++;
         $display("FAIL %s coin_count: got %0d want %0d", name, coin_count, exp_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      change_in = 16'd0;
      change_valid = 1'b0;
      hopper_empty = 4'b0000;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, coin_eject, done, residue, coin_count} !== 30'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b/%b/%b/%0d/%0d want all 0",
                  busy, coin_eject, done, residue, coin_count);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, coin_eject, done} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_release: got %b/%b/%b want 0", busy, coin_eject, done);
      end
   endtask

   task automatic test_random();
      int amt;
      logic [3:0] he;
      for (int i = 0; i < 10; i++) begin
         amt = $urandom_range(0, 400);
         he = 4'($urandom_range(0, 15));
         run_req("random", amt, he, he, 1'b0);
      end
   endtask

   task automatic test_reset_mid_eject();
      @(negedge clk);
      hopper_empty = 4'b0000;
      change_in = 16'd200;
      change_valid = 1'b1;
      for (int cyc = 1; cyc <= 2 + (G + 2); cyc++) begin
         @(negedge clk);
         if (cyc == 1) change_valid = 1'b0;
      end
      n_cmp++;
      if (coin_eject !== 4'b1000) begin
         n_bad++;
         $display("FAIL rst_mid second_pulse: got %b want 1000", coin_eject);
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({busy, coin_eject, done, residue, coin_count} !== 30'd0) begin
         n_bad++;
         $display("FAIL rst_mid outputs: got %b/%b/%b/%0d/%0d want all 0",
                  busy, coin_eject, done, residue, coin_count);
      end
      #1 reset = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         n_cmp++;
         if (coin_eject !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid after_release cyc %0d: eject %b busy %b want 0", cyc, coin_eject, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      run_req("change_65", 65, 4'b0000, 4'b0000, 1'b0);
      run_req("no_100", 100, 4'b1000, 4'b1000, 1'b0);
      run_req("residue_7", 7, 4'b0000, 4'b0000, 1'b0);
      run_req("zero", 0, 4'b0000, 4'b0000, 1'b0);
      run_req("ignore_busy", 75, 4'b0000, 4'b0000, 1'b1);
      run_req("gap_flag", 50, 4'b0000, 4'b0100, 1'b0);
      run_req("unpayable", 30, 4'b0111, 4'b0111, 1'b0);
      run_req("max_amount", 65535, 4'b0000, 4'b0000, 1'b0);
      test_random();
      run_req("saturate", 1500, 4'b1110, 4'b1110, 1'b0);
      test_reset_mid_eject();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
